// File: rtl/pg_regs_pkg.sv
// Shared constants for the pulse-generator register file.
// Holds the per-channel register offsets, channel stride, CTRL/STATUS bit
// positions and the commit FSM state encoding. No ports.
package pg_regs_pkg;

  localparam logic [3:0] OFF_ENA    = 4'h0;
  localparam logic [3:0] OFF_YEAR_H = 4'h1;
  localparam logic [3:0] OFF_YEAR_L = 4'h2;
  localparam logic [3:0] OFF_MONTH  = 4'h3;
  localparam logic [3:0] OFF_DAY    = 4'h4;
  localparam logic [3:0] OFF_HOUR   = 4'h5;
  localparam logic [3:0] OFF_MIN    = 4'h6;
  localparam logic [3:0] OFF_SEC    = 4'h7;
  localparam logic [3:0] OFF_WH2    = 4'h8;
  localparam logic [3:0] OFF_WH1    = 4'h9;
  localparam logic [3:0] OFF_WH0    = 4'hA;
  localparam logic [3:0] OFF_WP2    = 4'hB;
  localparam logic [3:0] OFF_WP1    = 4'hC;
  localparam logic [3:0] OFF_WP0    = 4'hD;
  localparam logic [3:0] OFF_CTRL   = 4'hE;
  localparam logic [3:0] OFF_STATUS = 4'hF;

  localparam int unsigned CH_STRIDE   = 16;
  localparam int unsigned REGS_PER_CH = 14;

  localparam int unsigned CTRL_COMMIT_BIT  = 0;
  localparam int unsigned CTRL_ABORT_BIT   = 1;
  localparam int unsigned STATUS_ARMED_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT  = 1;

  typedef enum logic {
    StIdle  = 1'b0,
    StArmed = 1'b1
  } pg_state_e;

endpackage

// File: rtl/pg_channel_regs.sv
// One channel of the pulse-generator register file.
// With PG_SHADOW_EN defined: 14 shadow bytes, 14 active bytes, commit FSM
// (IDLE/ARMED) and STATUS. A committed set is copied to the active bytes on
// the next i_pps. Without PG_SHADOW_EN: writes land directly in the active
// bytes, CTRL/STATUS are inert and i_pps is ignored.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_wr, i_rd          write/read strobes already decoded for this channel
//   i_off, i_data       register offset and write data
//   i_pps               commit strobe
//   o_rdata             combinational read data, 0 unless i_rd
//   o_enable, o_usr_time, o_width_high, o_width_period  active values
//   o_commit_pending    channel armed
//   o_commit_done       one-cycle pulse after a copy
module pg_channel_regs
  import pg_regs_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr,
  input  logic            i_rd,
  input  logic [3:0]      i_off,
  input  logic [DW-1:0]   i_data,
  input  logic            i_pps,
  output logic [DW-1:0]   o_rdata,
  output logic [DW-1:0]   o_enable,
  output logic [7*DW-1:0] o_usr_time,
  output logic [3*DW-1:0] o_width_high,
  output logic [3*DW-1:0] o_width_period,
  output logic            o_commit_pending,
  output logic            o_commit_done
);

  logic [DW-1:0] active_q [REGS_PER_CH];
  logic          reg_wr;

  assign reg_wr = i_wr && (i_off <= OFF_WP0);

  // Offset order runs MS byte first, so lower offsets land in higher slots.
  always_comb begin
    o_enable = active_q[OFF_ENA];
    for (int k = 0; k < 7; k++) begin
      o_usr_time[(6-k)*DW +: DW] = active_q[1+k];
    end
    for (int k = 0; k < 3; k++) begin
      o_width_high[(2-k)*DW +: DW]   = active_q[8+k];
      o_width_period[(2-k)*DW +: DW] = active_q[11+k];
    end
  end

`ifdef PG_SHADOW_EN
  logic [DW-1:0] shadow_q [REGS_PER_CH];
  pg_state_e     state_q, state_d;
  logic          ctrl_wr, abort_wr, status_rd, copy;
  logic          done_q, sticky_q;

  assign ctrl_wr   = i_wr && (i_off == OFF_CTRL);
  assign abort_wr  = ctrl_wr && i_data[CTRL_ABORT_BIT];
  assign status_rd = i_rd && (i_off == OFF_STATUS);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (ctrl_wr && i_data[CTRL_COMMIT_BIT] && !i_data[CTRL_ABORT_BIT]) state_d = StArmed;
      end
      StArmed: begin
        if (abort_wr || i_pps) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Abort in the same cycle as i_pps suppresses the copy.
  always_comb begin
    copy             = (state_q == StArmed) && i_pps && !abort_wr;
    o_commit_pending = (state_q == StArmed);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REGS_PER_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      done_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (reg_wr) shadow_q[i_off] <= i_data;
      // Copies the pre-write shadow, so a same-cycle write stays shadow-only.
      if (copy) begin
        for (int i = 0; i < REGS_PER_CH; i++) active_q[i] <= shadow_q[i];
      end
      done_q <= copy;
      if (copy)           sticky_q <= 1'b1;
      else if (status_rd) sticky_q <= 1'b0;
    end
  end

  assign o_commit_done = done_q;

  always_comb begin
    o_rdata = '0;
    if (i_rd) begin
      if (i_off <= OFF_WP0) begin
        o_rdata = shadow_q[i_off];
      end else if (i_off == OFF_STATUS) begin
        o_rdata[STATUS_ARMED_BIT] = (state_q == StArmed);
        o_rdata[STATUS_DONE_BIT]  = sticky_q;
      end
    end
  end
`else
  logic pps_unused;
  assign pps_unused = i_pps;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REGS_PER_CH; i++) active_q[i] <= '0;
    end else if (reg_wr) begin
      active_q[i_off] <= i_data;
    end
  end

  assign o_commit_pending = 1'b0;
  assign o_commit_done    = 1'b0;

  always_comb begin
    o_rdata = '0;
    if (i_rd && (i_off <= OFF_WP0)) o_rdata = active_q[i_off];
  end
`endif

endmodule

// File: rtl/pulse_generator_regfile.sv
// Multi-channel register file for the pulse generators.
// N_CH channel register sets at a 16-byte stride from BASE_ADDR on the
// byte-wide register bus. Build option PG_SHADOW_EN enables shadow registers
// with an atomic commit on i_pps; without it writes go straight to the
// active outputs.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_wr, i_rd          bus strobes
//   i_addr, i_data      byte address and write data
//   o_data              registered read data (0 when not reading)
//   i_pps               commit strobe
//   o_enable, o_usr_time, o_width_high, o_width_period  active values, channel c
//                       in slice c of each bus
//   o_commit_pending    per-channel armed flag
//   o_commit_done       per-channel one-cycle commit pulse
module pulse_generator_regfile
  import pg_regs_pkg::*;
#(
  parameter int unsigned           N_CH       = 4,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h40,
  parameter int unsigned           DATA_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr,
  input  logic                         i_rd,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic [DATA_WIDTH-1:0]        o_data,
  input  logic                         i_pps,
  output logic [N_CH*DATA_WIDTH-1:0]   o_enable,
  output logic [N_CH*7*DATA_WIDTH-1:0] o_usr_time,
  output logic [N_CH*3*DATA_WIDTH-1:0] o_width_high,
  output logic [N_CH*3*DATA_WIDTH-1:0] o_width_period,
  output logic [N_CH-1:0]              o_commit_pending,
  output logic [N_CH-1:0]              o_commit_done
);

  localparam int unsigned DW = DATA_WIDTH;

  // One extra bit so the upper bound does not wrap for large N_CH.
  localparam logic [ADDR_WIDTH:0] AddrLo = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] AddrHi = AddrLo + (ADDR_WIDTH+1)'(CH_STRIDE * N_CH);

  logic [ADDR_WIDTH:0]   addr_ext;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] rel;
  logic [DW-1:0]         ch_rdata [N_CH];
  logic [DW-1:0]         rdata_d, rdata_q;

  assign addr_ext = {1'b0, i_addr};
  assign hit      = (addr_ext >= AddrLo) && (addr_ext < AddrHi);
  assign rel      = i_addr - BASE_ADDR;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic sel;
    assign sel = hit && (rel[ADDR_WIDTH-1:4] == (ADDR_WIDTH-4)'(c));

    pg_channel_regs #(
      .DW(DW)
    ) u_ch (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_wr            (i_wr && sel),
      .i_rd            (i_rd && sel),
      .i_off           (rel[3:0]),
      .i_data          (i_data),
      .i_pps           (i_pps),
      .o_rdata         (ch_rdata[c]),
      .o_enable        (o_enable[c*DW +: DW]),
      .o_usr_time      (o_usr_time[c*7*DW +: 7*DW]),
      .o_width_high    (o_width_high[c*3*DW +: 3*DW]),
      .o_width_period  (o_width_period[c*3*DW +: 3*DW]),
      .o_commit_pending(o_commit_pending[c]),
      .o_commit_done   (o_commit_done[c])
    );
  end

  // At most one channel is selected; the others drive 0.
  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < N_CH; c++) rdata_d = rdata_d | ch_rdata[c];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign o_data = rdata_q;

endmodule

// File: tb/tb_pulse_generator_regfile.sv
module tb_pulse_generator_regfile;

  localparam int unsigned N_CH = 4;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_wr;
  logic                 i_rd;
  logic [AW-1:0]        i_addr;
  logic [DW-1:0]        i_data;
  logic [DW-1:0]        o_data;
  logic                 i_pps;
  logic [N_CH*DW-1:0]   o_enable;
  logic [N_CH*7*DW-1:0] o_usr_time;
  logic [N_CH*3*DW-1:0] o_width_high;
  logic [N_CH*3*DW-1:0] o_width_period;
  logic [N_CH-1:0]      o_commit_pending;
  logic [N_CH-1:0]      o_commit_done;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  pulse_generator_regfile #(
    .N_CH      (N_CH),
    .ADDR_WIDTH(AW),
    .BASE_ADDR (8'h40),
    .DATA_WIDTH(DW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_wr            (i_wr),
    .i_rd            (i_rd),
    .i_addr          (i_addr),
    .i_data          (i_data),
    .o_data          (o_data),
    .i_pps           (i_pps),
    .o_enable        (o_enable),
    .o_usr_time      (o_usr_time),
    .o_width_high    (o_width_high),
    .o_width_period  (o_width_period),
    .o_commit_pending(o_commit_pending),
    .o_commit_done   (o_commit_done)
  );

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    i_addr = a; i_data = d; i_wr = 1'b1;
    @(posedge i_clk); #1;
    i_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    i_addr = a; i_rd = 1'b1;
    @(posedge i_clk); #1;
    i_rd = 1'b0;
    d = o_data;
  endtask

  task automatic pulse_pps();
    i_pps = 1'b1;
    @(posedge i_clk); #1;
    i_pps = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    checks++;
    if (o_enable !== '0 || o_usr_time !== '0 || o_width_high !== '0 || o_width_period !== '0) begin
      errors++; $display("FAIL reset_active: got %h/%h/%h/%h expected all 0",
                         o_enable, o_usr_time, o_width_high, o_width_period);
    end
    checks++;
    if (o_commit_pending !== '0 || o_commit_done !== '0 || o_data !== '0) begin
      errors++; $display("FAIL reset_flags: got pend=%b done=%b data=%h expected 0",
                         o_commit_pending, o_commit_done, o_data);
    end
    for (int a = 8'h40; a < 8'h80; a++) begin
      bus_read(8'(a), rd);
      checks++;
      if (rd !== 8'h00) begin
        errors++; $display("FAIL reset_read_%h: got %h expected 00", a, rd);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] rd;
    bus_write(8'h3F, 8'hFF);
    bus_write(8'h80, 8'hFF);
    bus_read(8'h3F, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL unmapped_3f: got %h expected 00", rd); end
    bus_read(8'h80, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL unmapped_80: got %h expected 00", rd); end
    checks++;
    if (o_enable !== 32'h0 || o_usr_time !== '0) begin
      errors++; $display("FAIL unmapped_write: got ena=%h expected 0", o_enable);
    end
  endtask

  task automatic test_rd_wr();
    logic [7:0] rd;
    bus_write(8'h42, 8'h11);
    i_addr = 8'h42; i_data = 8'h22; i_wr = 1'b1; i_rd = 1'b1;
    @(posedge i_clk); #1;
    i_wr = 1'b0; i_rd = 1'b0;
    checks++;
    if (o_data !== 8'h11) begin errors++; $display("FAIL rdwr_prewrite: got %h expected 11", o_data); end
    bus_read(8'h42, rd);
    checks++;
    if (rd !== 8'h22) begin errors++; $display("FAIL rdwr_after: got %h expected 22", rd); end
    @(posedge i_clk); #1;
    checks++;
    if (o_data !== 8'h00) begin errors++; $display("FAIL rdata_idle: got %h expected 00", o_data); end
  endtask

`ifdef PG_SHADOW_EN
  task automatic test_shadow_hold();
    logic [7:0] rd;
    bus_write(8'h55, 8'h17);
    bus_read(8'h55, rd);
    checks++;
    if (rd !== 8'h17) begin errors++; $display("FAIL shadow_read: got %h expected 17", rd); end
    checks++;
    if (o_usr_time[56+16 +: 8] !== 8'h00) begin
      errors++; $display("FAIL shadow_hold: got %h expected 00", o_usr_time[56+16 +: 8]);
    end
  endtask

  task automatic test_commit();
    logic [7:0] rd;
    bus_write(8'h6D, 8'hE8);
    bus_write(8'h6E, 8'h01);
    checks++;
    if (o_commit_pending !== 4'b0100) begin
      errors++; $display("FAIL commit_pending: got %b expected 0100", o_commit_pending);
    end
    checks++;
    if (o_width_period[48 +: 8] !== 8'h00) begin
      errors++; $display("FAIL commit_early: got %h expected 00", o_width_period[48 +: 8]);
    end
    pulse_pps();
    checks++;
    if (o_width_period[48 +: 8] !== 8'hE8 || o_commit_done !== 4'b0100) begin
      errors++; $display("FAIL commit_copy: got wp=%h done=%b expected e8/0100",
                         o_width_period[48 +: 8], o_commit_done);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_commit_done !== 4'b0000 || o_commit_pending !== 4'b0000) begin
      errors++; $display("FAIL commit_done_pulse: got done=%b pend=%b expected 0",
                         o_commit_done, o_commit_pending);
    end
    bus_read(8'h6F, rd);
    checks++;
    if (rd !== 8'h02) begin errors++; $display("FAIL status_first: got %h expected 02", rd); end
    bus_read(8'h6F, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL status_second: got %h expected 00", rd); end
  endtask

  task automatic test_commit_same_pps();
    bus_write(8'h70, 8'h33);
    i_addr = 8'h7E; i_data = 8'h01; i_wr = 1'b1; i_pps = 1'b1;
    @(posedge i_clk); #1;
    i_wr = 1'b0; i_pps = 1'b0;
    checks++;
    if (o_commit_pending[3] !== 1'b1 || o_enable[24 +: 8] !== 8'h00) begin
      errors++; $display("FAIL same_pps_nocopy: got pend=%b ena=%h expected 1/00",
                         o_commit_pending[3], o_enable[24 +: 8]);
    end
    pulse_pps();
    checks++;
    if (o_enable[24 +: 8] !== 8'h33 || o_commit_done[3] !== 1'b1) begin
      errors++; $display("FAIL same_pps_second: got ena=%h done=%b expected 33/1",
                         o_enable[24 +: 8], o_commit_done[3]);
    end
  endtask

  task automatic test_abort();
    bus_write(8'h40, 8'h99);
    bus_write(8'h4E, 8'h01);
    checks++;
    if (o_commit_pending[0] !== 1'b1) begin
      errors++; $display("FAIL abort_armed: got %b expected 1", o_commit_pending[0]);
    end
    bus_write(8'h4E, 8'h03);
    checks++;
    if (o_commit_pending[0] !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got %b expected 0", o_commit_pending[0]);
    end
    pulse_pps();
    checks++;
    if (o_enable[7:0] !== 8'h00 || o_commit_done[0] !== 1'b0) begin
      errors++; $display("FAIL abort_nocopy: got ena=%h done=%b expected 00/0",
                         o_enable[7:0], o_commit_done[0]);
    end
  endtask
`else
  task automatic test_direct_write();
    logic [7:0] rd;
    bus_write(8'h40, 8'h01);
    checks++;
    if (o_enable[7:0] !== 8'h01) begin
      errors++; $display("FAIL direct_ena: got %h expected 01", o_enable[7:0]);
    end
    bus_write(8'h55, 8'h17);
    checks++;
    if (o_usr_time[56+16 +: 8] !== 8'h17) begin
      errors++; $display("FAIL direct_hour: got %h expected 17", o_usr_time[56+16 +: 8]);
    end
    bus_read(8'h55, rd);
    checks++;
    if (rd !== 8'h17) begin errors++; $display("FAIL direct_read: got %h expected 17", rd); end
    bus_write(8'h71, 8'hAB);
    checks++;
    if (o_usr_time[3*56+48 +: 8] !== 8'hAB) begin
      errors++; $display("FAIL direct_year_h: got %h expected ab", o_usr_time[3*56+48 +: 8]);
    end
    bus_write(8'h68, 8'hC3);
    checks++;
    if (o_width_high[48+16 +: 8] !== 8'hC3) begin
      errors++; $display("FAIL direct_wh2: got %h expected c3", o_width_high[48+16 +: 8]);
    end
    bus_write(8'h6D, 8'hE8);
    checks++;
    if (o_width_period[48 +: 8] !== 8'hE8) begin
      errors++; $display("FAIL direct_wp0: got %h expected e8", o_width_period[48 +: 8]);
    end
  endtask

  task automatic test_ctrl_status_off();
    logic [7:0] rd;
    bus_write(8'h4E, 8'h01);
    checks++;
    if (o_commit_pending !== 4'b0000) begin
      errors++; $display("FAIL off_pending: got %b expected 0000", o_commit_pending);
    end
    bus_read(8'h4E, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL off_ctrl_read: got %h expected 00", rd); end
    bus_read(8'h4F, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL off_status_read: got %h expected 00", rd); end
    pulse_pps();
    checks++;
    if (o_commit_done !== 4'b0000 || o_enable !== 32'h0000_0001) begin
      errors++; $display("FAIL off_pps: got done=%b ena=%h expected 0000/00000001",
                         o_commit_done, o_enable);
    end
  endtask
`endif

  initial begin
    i_rst = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_pps = 1'b0;
    i_addr = '0; i_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    test_reset();
    test_unmapped();
    test_rd_wr();
`ifdef PG_SHADOW_EN
    test_shadow_hold();
    test_commit();
    test_commit_same_pps();
    test_abort();
`else
    test_direct_write();
    test_ctrl_status_off();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
